midi_voice_period_gen: RTL and testbench
========================================

Name: midi_voice_period_gen

Overview:
- Multi-voice successor to the single-note MIDI period lookup. Accepts note-on/off events per voice over a valid/ready handshake.
- Period is derived from a 12-entry base-octave table plus a right shift by octave, with octave found by sequential divide-by-12.
- Holds one period register per voice and drives a free-running square-wave tone per active voice.
- Sits between the MIDI message decoder and the audio mixer; 50 MHz clock domain.

Parameters:
- N_VOICES, 4, number of independent voices (1..16).
- PERIOD_W, 23, width of each period value; must be >=23. Upper bits above 23 read zero.
- VOICE_W, 4, width of note_voice; must satisfy 2^VOICE_W >= N_VOICES.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  synchronous, active-low reset.
- note_valid  in  1  event request.
- note_ready  out  1  block can accept an event (IDLE only).
- note_voice  in  VOICE_W  target voice index.
- note_num  in  7  MIDI note number 0..127.
- note_on  in  1  1 = note-on, 0 = note-off.
- period_o  out  N_VOICES*PERIOD_W  packed per-voice period, in full clock cycles; voice v at bits [v*PERIOD_W +: PERIOD_W].
- active_o  out  N_VOICES  per-voice active flag.
- tone_o  out  N_VOICES  per-voice square wave.

Behaviour:
- Reset is synchronous active-low; Reset_n is sampled on Clk rising edge. While asserted:
  - FSM goes to IDLE; note_ready=0.
  - period_o, active_o, tone_o and all tone counters are 0.
  - note_ready=1 from the first cycle after release.
- Base table for octave 0, indexed 0..11, in hex: 5D511A, 58144F, 5322C5, 4E7842, 4A10CB, 45E89B, 41FC25, 3E4810, 3AC931, 377C8B, 345F4E, 316ECF.
- Period(n) = base[n mod 12] >> (n div 12). This gives 0x5D511A for n=0, 0x1BBE4 for n=69, and 0xF92 for n=127.
- Period(n) is zero-extended to PERIOD_W.
- FSM states:
  - IDLE: note_ready=1. On note_valid&&note_ready, latch voice, note and on-flag; set rem=note, oct=0; go to DIV.
  - DIV: if rem>=12 then rem-=12 and oct+=1, stay in DIV; else go to WRITE. oct is 4 bits; rem is 7 bits.
  - WRITE: if voice < N_VOICES, apply the event (rules below). Then go to IDLE.
- Accept latency: a note accepted at edge E updates outputs at edge E+(n div 12)+2. note_ready returns to 1 on that same edge.
  - n=0: 2 cycles. n=69: 7 cycles. n=127: 12 cycles.
- Note-off events also traverse DIV/WRITE, so latency is identical.
- note_valid while note_ready=0 is ignored. There is no queueing; the upstream block holds valid until accepted.
- WRITE with note_on=1:
  - period[v] <= Period(n).
  - active[v] <= 1.
  - tone counter[v] <= 0 and tone[v] <= 0. A retrigger on an already active voice restarts its phase.
- WRITE with note_on=0:
  - active[v] <= 0; counter[v] <= 0; tone[v] <= 0.
  - period[v] keeps its last value.
- Voice index >= N_VOICES: the event is consumed with normal latency and causes no state change.
- Tone generators run every cycle, independently of the FSM.
  - Inactive voice: counter and tone held at 0.
  - Active voice: half = period[v] >> 1. If counter >= half-1, counter <= 0 and tone toggles; else counter increments.
  - Result: tone_o toggles every half cycles (half = 56818 for n=69, i.e. about 440 Hz).
  - The counter is PERIOD_W bits wide.
- WRITE to voice v on the same edge as a tone wrap of voice v: the WRITE wins.
- Reset asserted mid-DIV: the event is abandoned and all state is cleared.

Optional Feature:
- Macro: MIDI_TRANSPOSE_EN.
- Defined:
  - Adds input transpose_i, signed 5 bits (-16..+15), sampled at accept.
  - Effective note = clamp(note_num + transpose_i, 0, 127), computed before DIV. Latency uses the effective note.
- Undefined:
  - transpose_i is absent.
  - note_num is used directly.

Test Plan:
1. Release reset, then note-on v0 n=69. Expect:
   - note_ready low for 7 cycles.
   - period_o[v0]=0x1BBE4 and active_o[0]=1.
   - tone_o[0] toggles every 56818 cycles.
2. Note-on v1 n=0, then v2 n=127. Expect:
   - v1: period 0x5D511A after a 2-cycle latency.
   - v2: period 0xF92 after a 12-cycle latency.
   - v0 tone undisturbed.
3. Note-off v0 while tone_o[0]=1. Expect on the WRITE edge: active_o[0]=0 and tone_o[0]=0, with period_o[v0] still 0x1BBE4.
4. Hold note_valid high across a busy period with changing note_num. Expect:
   - Exactly one acceptance per IDLE.
   - The second event is accepted on the cycle ready returns.
5. note_voice=7 with N_VOICES=4, then reset asserted mid-DIV on a new event. Expect:
   - The voice-7 event causes no output change.
   - After reset, all outputs are 0 and note_ready=1 one cycle after release.
6. With MIDI_TRANSPOSE_EN defined:
   - n=120 with transpose=+15 → period 0xF92.
   - n=3 with transpose=-16 → period 0x5D511A, latency 2.

Source files
------------

// File: rtl/midi_voice_period_gen.sv
// Multi-voice MIDI note-to-period generator with per-voice square-wave tones.
// Optional MIDI_TRANSPOSE_EN adds a signed transpose input applied at accept.
module midi_voice_period_gen #(
  parameter int N_VOICES = 4,
  parameter int PERIOD_W = 23,
  parameter int VOICE_W  = 4
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         note_valid,
  output logic                         note_ready,
  input  logic [VOICE_W-1:0]           note_voice,
  input  logic [6:0]                   note_num,
  input  logic                         note_on,
`ifdef MIDI_TRANSPOSE_EN
  input  logic signed [4:0]            transpose_i,
`endif
  output logic [N_VOICES*PERIOD_W-1:0] period_o,
  output logic [N_VOICES-1:0]          active_o,
  output logic [N_VOICES-1:0]          tone_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, WRITE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [VOICE_W-1:0]   voice_q, voice_d;
  logic                 on_q, on_d;
  logic [6:0]           rem_q, rem_d;
  logic [3:0]           oct_q, oct_d;
  logic [PERIOD_W-1:0]  period_q [N_VOICES];
  logic [PERIOD_W-1:0]  period_d [N_VOICES];
  logic [PERIOD_W-1:0]  cnt_q [N_VOICES];
  logic [PERIOD_W-1:0]  cnt_d [N_VOICES];
  logic [N_VOICES-1:0]  active_q, active_d, tone_q, tone_d;
  logic [6:0]           note_eff;
  logic [22:0]          base;
  logic [PERIOD_W-1:0]  period_new;
  logic [PERIOD_W-1:0]  half;

`ifdef MIDI_TRANSPOSE_EN
  logic signed [8:0] note_sum;
  // Sum is at most 142, so bit 8 flags negative and bit 7 flags overflow past 127.
  always_comb begin
    note_sum = $signed({2'b00, note_num}) + $signed({{4{transpose_i[4]}}, transpose_i});
    if (note_sum[8])      note_eff = '0;
    else if (note_sum[7]) note_eff = '1;
    else                  note_eff = note_sum[6:0];
  end
`else
  assign note_eff = note_num;
`endif

  always_comb begin
    case (rem_q)
      7'd0:    base = 23'h5D511A;
      7'd1:    base = 23'h58144F;
      7'd2:    base = 23'h5322C5;
      7'd3:    base = 23'h4E7842;
      7'd4:    base = 23'h4A10CB;
      7'd5:    base = 23'h45E89B;
      7'd6:    base = 23'h41FC25;
      7'd7:    base = 23'h3E4810;
      7'd8:    base = 23'h3AC931;
      7'd9:    base = 23'h377C8B;
      7'd10:   base = 23'h345F4E;
      7'd11:   base = 23'h316ECF;
      default: base = '0;
    endcase
    period_new = PERIOD_W'(base >> oct_q);
  end

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    voice_d  = voice_q;
    on_d     = on_q;
    rem_d    = rem_q;
    oct_d    = oct_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    tone_d   = tone_q;
    half     = '0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (note_valid && ready_q) begin
          voice_d = note_voice;
          on_d    = note_on;
          rem_d   = note_eff;
          oct_d   = '0;
          ready_d = 1'b0;
          state_d = DIV;
        end
      end
      DIV: begin
        if (rem_q >= 7'd12) begin
          rem_d = rem_q - 7'd12;
          oct_d = oct_q + 4'd1;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase

    for (int unsigned v = 0; v < N_VOICES; v++) begin
      half = period_q[v] >> 1;
      if (!active_q[v]) begin
        cnt_d[v]  = '0;
        tone_d[v] = 1'b0;
      end else if (cnt_q[v] >= half - PERIOD_W'(1)) begin
        cnt_d[v]  = '0;
        tone_d[v] = ~tone_q[v];
      end else begin
        cnt_d[v] = cnt_q[v] + PERIOD_W'(1);
      end
      // A WRITE overrides the tone update above; out-of-range voices match nothing.
      if (state_q == WRITE && voice_q == VOICE_W'(v)) begin
        if (on_q) period_d[v] = period_new;
        active_d[v] = on_q;
        cnt_d[v]    = '0;
        tone_d[v]   = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      voice_q  <= '0;
      on_q     <= 1'b0;
      rem_q    <= '0;
      oct_q    <= '0;
      period_q <= '{default: '0};
      cnt_q    <= '{default: '0};
      active_q <= '0;
      tone_q   <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      voice_q  <= voice_d;
      on_q     <= on_d;
      rem_q    <= rem_d;
      oct_q    <= oct_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      tone_q   <= tone_d;
    end
  end

  always_comb begin
    period_o = '0;
    for (int unsigned v = 0; v < N_VOICES; v++) begin
      period_o[v*PERIOD_W +: PERIOD_W] = period_q[v];
    end
  end

  assign note_ready = ready_q;
  assign active_o   = active_q;
  assign tone_o     = tone_q;

endmodule

// File: tb/tb_midi_voice_period_gen.sv
// Directed bench for midi_voice_period_gen: latency, periods, tones, reset.
// Define MIDI_TRANSPOSE_EN to also exercise the transpose path.
module tb_midi_voice_period_gen;
  localparam int NV = 4;
  localparam int PW = 23;
  localparam int VW = 4;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              note_valid;
  logic              note_ready;
  logic [VW-1:0]     note_voice;
  logic [6:0]        note_num;
  logic              note_on;
  logic [NV*PW-1:0]  period_o;
  logic [NV-1:0]     active_o;
  logic [NV-1:0]     tone_o;
`ifdef MIDI_TRANSPOSE_EN
  logic signed [4:0] transpose_i;
`endif

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned w0, w2;

  midi_voice_period_gen #(.N_VOICES(NV), .PERIOD_W(PW), .VOICE_W(VW)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_voice (note_voice),
    .note_num   (note_num),
    .note_on    (note_on),
`ifdef MIDI_TRANSPOSE_EN
    .transpose_i(transpose_i),
`endif
    .period_o   (period_o),
    .active_o   (active_o),
    .tone_o     (tone_o)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] per(input int v);
    return period_o[v*PW +: PW];
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) tick();
  endtask

  // Waits for ready, presents one event for exactly one accept edge, returns cycles until ready returns.
  task automatic issue(input logic [VW-1:0] v, input logic [6:0] n, input logic on, output int lat);
    int guard;
    guard = 0;
    while (note_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (note_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout got %b exp 1", note_ready);
    end
    note_voice = v; note_num = n; note_on = on; note_valid = 1'b1;
    tick();
    note_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (note_ready !== 1'b1 && lat < 50);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; note_valid = 1'b0; note_voice = '0; note_num = '0; note_on = 1'b0;
`ifdef MIDI_TRANSPOSE_EN
    transpose_i = '0;
`endif
    repeat (3) tick();
    checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", note_ready); end
    checks++; if (period_o !== '0) begin errors++; $display("FAIL rst_period got %h exp 0", period_o); end
    checks++; if (active_o !== '0) begin errors++; $display("FAIL rst_active got %b exp 0", active_o); end
    checks++; if (tone_o !== '0) begin errors++; $display("FAIL rst_tone got %b exp 0", tone_o); end
    Reset_n = 1'b1;
    tick();
    checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", note_ready); end
  endtask

  task automatic test_note_on_a4();
    int lat;
    issue(4'd0, 7'd69, 1'b1, lat);
    w0 = cyc;
    checks++; if (lat != 7) begin errors++; $display("FAIL a4_latency got %0d exp 7", lat); end
    checks++; if (per(0) !== 23'h01BBE4) begin errors++; $display("FAIL a4_period got %h exp 01bbe4", per(0)); end
    checks++; if (active_o[0] !== 1'b1) begin errors++; $display("FAIL a4_active got %b exp 1", active_o[0]); end
    checks++; if (tone_o[0] !== 1'b0) begin errors++; $display("FAIL a4_tone_start got %b exp 0", tone_o[0]); end
  endtask

  task automatic test_multi_voice();
    int lat;
    issue(4'd1, 7'd0, 1'b1, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL v1_latency got %0d exp 2", lat); end
    checks++; if (per(1) !== 23'h5D511A) begin errors++; $display("FAIL v1_period got %h exp 5d511a", per(1)); end
    issue(4'd2, 7'd127, 1'b1, lat);
    w2 = cyc;
    checks++; if (lat != 12) begin errors++; $display("FAIL v2_latency got %0d exp 12", lat); end
    checks++; if (per(2) !== 23'h000F92) begin errors++; $display("FAIL v2_period got %h exp 000f92", per(2)); end
    checks++; if (active_o !== 4'b0111) begin errors++; $display("FAIL multi_active got %b exp 0111", active_o); end
    // 0xF92 >> 1 = 1993 cycles per half period
    wait_cyc(w2 + 1992);
    checks++; if (tone_o[2] !== 1'b0) begin errors++; $display("FAIL v2_pre_toggle got %b exp 0", tone_o[2]); end
    wait_cyc(w2 + 1993);
    checks++; if (tone_o[2] !== 1'b1) begin errors++; $display("FAIL v2_toggle1 got %b exp 1", tone_o[2]); end
    wait_cyc(w2 + 3985);
    checks++; if (tone_o[2] !== 1'b1) begin errors++; $display("FAIL v2_pre_toggle2 got %b exp 1", tone_o[2]); end
    wait_cyc(w2 + 3986);
    checks++; if (tone_o[2] !== 1'b0) begin errors++; $display("FAIL v2_toggle2 got %b exp 0", tone_o[2]); end
    wait_cyc(w0 + 56817);
    checks++; if (tone_o[0] !== 1'b0) begin errors++; $display("FAIL v0_pre_toggle got %b exp 0", tone_o[0]); end
    checks++; if (per(0) !== 23'h01BBE4) begin errors++; $display("FAIL v0_period_kept got %h exp 01bbe4", per(0)); end
    wait_cyc(w0 + 56818);
    checks++; if (tone_o[0] !== 1'b1) begin errors++; $display("FAIL v0_toggle got %b exp 1", tone_o[0]); end
  endtask

  task automatic test_note_off();
    int lat;
    checks++; if (tone_o[0] !== 1'b1) begin errors++; $display("FAIL off_pre_tone got %b exp 1", tone_o[0]); end
    issue(4'd0, 7'd69, 1'b0, lat);
    checks++; if (lat != 7) begin errors++; $display("FAIL off_latency got %0d exp 7", lat); end
    checks++; if (active_o !== 4'b0110) begin errors++; $display("FAIL off_active got %b exp 0110", active_o); end
    checks++; if (tone_o[0] !== 1'b0) begin errors++; $display("FAIL off_tone got %b exp 0", tone_o[0]); end
    checks++; if (per(0) !== 23'h01BBE4) begin errors++; $display("FAIL off_period got %h exp 01bbe4", per(0)); end
  endtask

  task automatic test_back_to_back();
    note_voice = 4'd3; note_num = 7'd12; note_on = 1'b1; note_valid = 1'b1;
    tick();
    checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept1 got %b exp 0", note_ready); end
    note_num = 7'd100;
    tick();
    note_num = 7'd50;
    tick();
    checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy1 got %b exp 0", note_ready); end
    tick();
    checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b exp 1", note_ready); end
    checks++; if (per(3) !== 23'h2EA88D) begin errors++; $display("FAIL b2b_period1 got %h exp 2ea88d", per(3)); end
    checks++; if (active_o[3] !== 1'b1) begin errors++; $display("FAIL b2b_active got %b exp 1", active_o[3]); end
    note_num = 7'd24;
    tick();
    checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept2 got %b exp 0", note_ready); end
    note_num = 7'd99;
    repeat (3) tick();
    checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy2 got %b exp 0", note_ready); end
    tick();
    checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2 got %b exp 1", note_ready); end
    checks++; if (per(3) !== 23'h175446) begin errors++; $display("FAIL b2b_period2 got %h exp 175446", per(3)); end
    note_valid = 1'b0;
    tick();
    checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_extra got %b exp 1", note_ready); end
  endtask

  task automatic test_bad_voice_and_reset();
    int lat;
    logic [NV*PW-1:0] exp_p;
    exp_p = {23'h175446, 23'h000F92, 23'h5D511A, 23'h01BBE4};
    issue(4'd7, 7'd5, 1'b1, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL v7_latency got %0d exp 2", lat); end
    checks++; if (period_o !== exp_p) begin errors++; $display("FAIL v7_period got %h exp %h", period_o, exp_p); end
    checks++; if (active_o !== 4'b1110) begin errors++; $display("FAIL v7_active got %b exp 1110", active_o); end
    issue(4'd7, 7'd5, 1'b0, lat);
    checks++; if (active_o !== 4'b1110) begin errors++; $display("FAIL v7_off_active got %b exp 1110", active_o); end
    note_voice = 4'd1; note_num = 7'd100; note_on = 1'b1; note_valid = 1'b1;
    tick();
    note_valid = 1'b0;
    tick();
    tick();
    Reset_n = 1'b0;
    tick();
    checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL middiv_rst_ready got %b exp 0", note_ready); end
    checks++; if (period_o !== '0) begin errors++; $display("FAIL middiv_rst_period got %h exp 0", period_o); end
    checks++; if (active_o !== '0 || tone_o !== '0) begin errors++; $display("FAIL middiv_rst_act_tone got %b/%b exp 0/0", active_o, tone_o); end
    tick();
    Reset_n = 1'b1;
    tick();
    checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL middiv_release_ready got %b exp 1", note_ready); end
    repeat (12) tick();
    checks++; if (period_o !== '0 || active_o !== '0) begin errors++; $display("FAIL middiv_abandoned got %h/%b exp 0/0", period_o, active_o); end
    issue(4'd0, 7'd0, 1'b1, lat);
    checks++; if (lat != 2 || per(0) !== 23'h5D511A) begin errors++; $display("FAIL post_rst_event got %0d/%h exp 2/5d511a", lat, per(0)); end
  endtask

`ifdef MIDI_TRANSPOSE_EN
  task automatic test_transpose();
    int lat;
    transpose_i = 5'sd15;
    issue(4'd1, 7'd120, 1'b1, lat);
    checks++; if (lat != 12) begin errors++; $display("FAIL tp_up_latency got %0d exp 12", lat); end
    checks++; if (per(1) !== 23'h000F92) begin errors++; $display("FAIL tp_up_period got %h exp 000f92", per(1)); end
    transpose_i = -5'sd16;
    issue(4'd1, 7'd3, 1'b1, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL tp_down_latency got %0d exp 2", lat); end
    checks++; if (per(1) !== 23'h5D511A) begin errors++; $display("FAIL tp_down_period got %h exp 5d511a", per(1)); end
    transpose_i = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_note_on_a4();
    test_multi_voice();
    test_note_off();
    test_back_to_back();
    test_bad_voice_and_reset();
`ifdef MIDI_TRANSPOSE_EN
    test_transpose();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout got cycle %0d exp completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
